// File: rtl/avalon_mm_burst_slave_if.sv
// avalon_mm_burst_slave_if
//   Avalon-MM bus bundle between a burst-capable master and the word-store slave.
//   Ports (seen from the slave modport):
//     avs_address        in   ADDR_W    byte address, bits [1:0] ignored
//     avs_read           in   1         read request
//     avs_write          in   1         write request / write beat
//     avs_writedata      in   DATA_W    write data
//     avs_byteenable     in   DATA_W/8  per-byte write enable
//     avs_burstcount     in   BURST_W   beats in burst (first beat only)
//     avs_waitrequest    out  1         slave stall
//     avs_readdata       out  DATA_W    read data
//     avs_readdatavalid  out  1         read data valid
interface avalon_mm_burst_slave_if #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 4
);
    logic [ADDR_W-1:0]   avs_address;
    logic                avs_read;
    logic                avs_write;
    logic [DATA_W-1:0]   avs_writedata;
    logic [DATA_W/8-1:0] avs_byteenable;
    logic [BURST_W-1:0]  avs_burstcount;
    logic                avs_waitrequest;
    logic [DATA_W-1:0]   avs_readdata;
    logic                avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_burstcount,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_burstcount,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/avalon_mm_burst_slave.sv
// avalon_mm_burst_slave
//   Avalon-MM responder with a DEPTH x DATA_W word store, byteenable writes,
//   burst writes/reads and a fixed-latency pipelined read return.
//   Ports:
//     clk_clk         in   1   system clock
//     reset_n         in   1   asynchronous active-low reset
//     avs             slave    Avalon-MM bus (see avalon_mm_burst_slave_if)
//     protocol_error  out  1   sticky flag: read and write requested together
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | ready for a command; waitrequest low (except first cycle
//              | after reset release)
//   S_WR_BURST | accepting remaining write beats at r_ptr; waitrequest low
//   S_RD_BURST | issuing one read beat per cycle into the pipe; waitrequest high
module avalon_mm_burst_slave #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int BURST_W      = 4,
    parameter int MAX_BURST    = 8,
    parameter int DEPTH        = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk_clk,
    input  logic                   reset_n,
    avalon_mm_burst_slave_if.slave avs,
    output logic                   protocol_error
);
    localparam int NUM_SYMBOLS = DATA_W / 8;
    localparam int IDX_W       = $clog2(DEPTH);
    localparam int CNT_W       = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR_BURST = 2'd1,
        S_RD_BURST = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        w_ptr_nxt;
    logic [CNT_W-1:0]        r_remaining;
    logic [CNT_W-1:0]        w_rem_nxt;
    logic                    r_waitrequest;
    logic                    r_protocol_error;

    logic [DATA_W-1:0]       r_mem [DEPTH];

    logic [IDX_W-1:0]        w_addr_idx;
    logic [CNT_W-1:0]        w_bc;
    logic                    w_mem_we;
    logic [IDX_W-1:0]        w_mem_idx;
    logic                    w_issue;
    logic                    w_err_set;

    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [DATA_W-1:0]       r_pipe_dat [READ_LATENCY];

    // Address bits outside the word index carry no meaning for this store.
    logic                    w_unused;
    assign w_unused = &{1'b0, avs.avs_address[1:0], avs.avs_address[ADDR_W-1:2+IDX_W]};

    assign w_addr_idx = avs.avs_address[2 +: IDX_W];

    // Zero means a single beat; oversized bursts are clamped rather than rejected.
    always_comb begin
        if (avs.avs_burstcount == '0) begin
            w_bc = CNT_W'(1);
        end else if (int'(avs.avs_burstcount) > MAX_BURST) begin
            w_bc = CNT_W'(MAX_BURST);
        end else begin
            w_bc = CNT_W'(avs.avs_burstcount);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_rem_nxt   = r_remaining;
        w_mem_we    = 1'b0;
        w_mem_idx   = r_ptr;
        w_issue     = 1'b0;
        w_err_set   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The first post-reset cycle still shows waitrequest, so nothing transfers.
                if (!r_waitrequest) begin
                    if (avs.avs_write) begin
                        w_mem_we  = 1'b1;
                        w_mem_idx = w_addr_idx;
                        w_err_set = avs.avs_read;
                        if (w_bc > CNT_W'(1)) begin
                            w_state_nxt = S_WR_BURST;
                            w_rem_nxt   = w_bc - CNT_W'(1);
                            w_ptr_nxt   = w_addr_idx + IDX_W'(1);
                        end
                    end else if (avs.avs_read) begin
                        w_state_nxt = S_RD_BURST;
                        w_rem_nxt   = w_bc;
                        w_ptr_nxt   = w_addr_idx;
                    end
                end
            end

            S_WR_BURST: begin
                if (avs.avs_write) begin
                    w_mem_we  = 1'b1;
                    w_mem_idx = r_ptr;
                    w_ptr_nxt = r_ptr + IDX_W'(1);
                    w_rem_nxt = r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_RD_BURST: begin
                w_issue   = 1'b1;
                w_ptr_nxt = r_ptr + IDX_W'(1);
                w_rem_nxt = r_remaining - CNT_W'(1);
                if (r_remaining == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_ptr            <= '0;
            r_remaining      <= '0;
            r_waitrequest    <= 1'b1;
            r_protocol_error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_remaining   <= w_rem_nxt;
            // Stall only while read beats are being issued.
            r_waitrequest <= (w_state_nxt == S_RD_BURST);
            if (w_err_set) begin
                r_protocol_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                r_mem[w] <= '0;
            end
        end else if (w_mem_we) begin
            for (int b = 0; b < NUM_SYMBOLS; b++) begin
                if (avs.avs_byteenable[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= avs.avs_writedata[8*b +: 8];
                end
            end
        end
    end

    // Data is captured at issue, so writes after issue cannot disturb in-flight beats.
    // Each stage loads only on a valid beat, so the last stage holds the previous
    // readdata while readdatavalid is low.
    always_ff @(posedge clk_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_dat[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_issue;
            if (w_issue) begin
                r_pipe_dat[0] <= r_mem[r_ptr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) begin
                    r_pipe_dat[i] <= r_pipe_dat[i-1];
                end
            end
        end
    end

    assign avs.avs_waitrequest   = r_waitrequest;
    assign avs.avs_readdatavalid = r_pipe_vld[READ_LATENCY-1];
    assign avs.avs_readdata      = r_pipe_dat[READ_LATENCY-1];
    assign protocol_error        = r_protocol_error;

endmodule
